// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared types and constants for the RV32 front-end fetch controller.
//   ctrl_state_t  : controller state encoding (RUN, STALL, FLUSH, HALTED)
//   FLUSH_CNT_W   : width of the post-redirect squash counter
//   STALL_CNT_MAX : saturation value of the stall-cycle counter
//   DEFAULT_XLEN  : address width taken from `XLEN (falls back to 32)

`ifndef XLEN
`define XLEN 32
`endif

package fetch_ctrl_pkg;

    localparam int          DEFAULT_XLEN  = `XLEN;
    localparam int          FLUSH_CNT_W   = 3;
    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if
// Bundle of request and control signals between decode/execute, the fetch
// controller and the fetch stage.
//   Requests  : stall_req, br_req, br_target, halt_req, resume, perf_clr
//               (+ trap_req, trap_pc when FETCH_CTRL_TRAP_EN is defined)
//   Results   : halt, branch_en, branch_addr, flush_if, flush_id,
//               ctrl_state, stall_cycles (+ epc when FETCH_CTRL_TRAP_EN)
//   master    : the fetch controller side
//   slave     : the pipeline side that raises requests and consumes results
// Optional feature macro: FETCH_CTRL_TRAP_EN

interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
);

    logic            stall_req;
    logic            br_req;
    logic [XLEN-1:0] br_target;
    logic            halt_req;
    logic            resume;
    logic            perf_clr;
`ifdef FETCH_CTRL_TRAP_EN
    logic            trap_req;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] epc;
`endif
    logic            halt;
    logic            branch_en;
    logic [XLEN-1:0] branch_addr;
    logic            flush_if;
    logic            flush_id;
    ctrl_state_t     ctrl_state;
    logic [31:0]     stall_cycles;

    modport master (
        input  stall_req, br_req, br_target, halt_req, resume, perf_clr,
`ifdef FETCH_CTRL_TRAP_EN
        input  trap_req, trap_pc,
        output epc,
`endif
        output halt, branch_en, branch_addr, flush_if, flush_id,
        output ctrl_state, stall_cycles
    );

    modport slave (
        output stall_req, br_req, br_target, halt_req, resume, perf_clr,
`ifdef FETCH_CTRL_TRAP_EN
        output trap_req, trap_pc,
        input  epc,
`endif
        input  halt, branch_en, branch_addr, flush_if, flush_id,
        input  ctrl_state, stall_cycles
    );

endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// sat_counter
// Generic up-counter with synchronous clear and saturation at MAX_VAL.
//   clk, rst : clock and asynchronous active-low reset
//   clr_i    : clear to zero (wins over increment)
//   inc_i    : increment by one unless already at MAX_VAL
//   count_o  : current count

module sat_counter #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_VAL)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Front-end pipeline controller: arbitrates trap/branch/halt/stall requests,
// drives the fetch stage's halt/branch_en/branch_addr, squashes wrong-path
// instructions in IF/ID and ID/EX, and counts stall cycles.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : fetch_ctrl_if master modport (requests in, registered results out)
// Parameters: XLEN, FLUSH_CYCLES (1..7), TRAP_VEC (only with the macro)
// Optional feature macro: FETCH_CTRL_TRAP_EN adds trap redirect and epc.

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN         = DEFAULT_XLEN,
    parameter int FLUSH_CYCLES = 2
`ifdef FETCH_CTRL_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
`endif
) (
    input logic          clk,
    input logic          rst,
    fetch_ctrl_if.master bus
);

    ctrl_state_t            state_q,      state_d;
    logic [FLUSH_CNT_W-1:0] flushCnt_q,   flushCnt_d;
    logic                   halt_q,       halt_d;
    logic                   branchEn_q,   branchEn_d;
    logic [XLEN-1:0]        branchAddr_q, branchAddr_d;
    logic                   flushIf_q,    flushIf_d;
    logic                   flushId_q,    flushId_d;
`ifdef FETCH_CTRL_TRAP_EN
    logic [XLEN-1:0]        epc_q,        epc_d;
`endif
    logic                   redirect;
    logic [XLEN-1:0]        redirTarget;

    // Redirects are resolved first so they override halt/stall; the trap
    // check is placed in front of the branch check so a trap always wins.
    always_comb begin
        state_d      = state_q;
        flushCnt_d   = flushCnt_q;
        halt_d       = halt_q;
        branchEn_d   = 1'b0;
        branchAddr_d = branchAddr_q;
        flushIf_d    = 1'b0;
        flushId_d    = 1'b0;
        redirect     = 1'b0;
        redirTarget  = bus.br_target;
`ifdef FETCH_CTRL_TRAP_EN
        epc_d        = epc_q;

        if (bus.trap_req && (state_q != HALTED)) begin
            redirect    = 1'b1;
            redirTarget = TRAP_VEC;
            epc_d       = bus.trap_pc;
        end else
`endif
        if (bus.br_req && ((state_q == RUN) || (state_q == STALL))) begin
            redirect    = 1'b1;
            redirTarget = bus.br_target;
        end

        if (redirect) begin
            state_d      = FLUSH;
            flushCnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            halt_d       = 1'b0;
            branchEn_d   = 1'b1;
            branchAddr_d = redirTarget & ~XLEN'(3);
            flushIf_d    = 1'b1;
            flushId_d    = 1'b1;
        end else begin
            unique case (state_q)
                RUN, STALL: begin
                    if (bus.halt_req) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end else if (bus.stall_req) begin
                        state_d = STALL;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        halt_d  = 1'b0;
                    end
                end
                // Squash stays asserted for FLUSH_CYCLES cycles in total:
                // the redirect edge plus one per non-zero counter value.
                FLUSH: begin
                    halt_d = 1'b0;
                    if (flushCnt_q != '0) begin
                        flushCnt_d = flushCnt_q - FLUSH_CNT_W'(1);
                        flushIf_d  = 1'b1;
                        flushId_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                HALTED: begin
                    if (bus.resume) begin
                        state_d = RUN;
                        halt_d  = 1'b0;
                    end else begin
                        halt_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                    halt_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            flushCnt_q   <= '0;
            halt_q       <= 1'b0;
            branchEn_q   <= 1'b0;
            branchAddr_q <= '0;
            flushIf_q    <= 1'b0;
            flushId_q    <= 1'b0;
`ifdef FETCH_CTRL_TRAP_EN
            epc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            flushCnt_q   <= flushCnt_d;
            halt_q       <= halt_d;
            branchEn_q   <= branchEn_d;
            branchAddr_q <= branchAddr_d;
            flushIf_q    <= flushIf_d;
            flushId_q    <= flushId_d;
`ifdef FETCH_CTRL_TRAP_EN
            epc_q        <= epc_d;
`endif
        end
    end

    // Only cycles where fetch is actually held while stalled are counted.
    sat_counter #(
        .WIDTH   (32),
        .MAX_VAL (STALL_CNT_MAX)
    ) u_stallCnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.perf_clr),
        .inc_i   ((state_q == STALL) && halt_q),
        .count_o (bus.stall_cycles)
    );

    assign bus.halt        = halt_q;
    assign bus.branch_en   = branchEn_q;
    assign bus.branch_addr = branchAddr_q;
    assign bus.flush_if    = flushIf_q;
    assign bus.flush_id    = flushId_q;
    assign bus.ctrl_state  = state_q;
`ifdef FETCH_CTRL_TRAP_EN
    assign bus.epc         = epc_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Directed self-checking bench for fetch_ctrl. Expected redirect addresses
// are queued when a redirect is requested and consumed whenever branch_en
// is observed; all other expectations are written inline at each step.
// Optional feature macro: FETCH_CTRL_TRAP_EN enables the trap steps.

module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int XLEN = 32;

    logic clk;
    logic rst;

    int checkCount;
    int passCount;
    int failCount;

    logic [XLEN-1:0] expAddrQ [$];

    fetch_ctrl_if #(.XLEN(XLEN)) bus ();

    fetch_ctrl #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge and retire a queued redirect
    // whenever branch_en shows up.
    task automatic tick();
        logic [XLEN-1:0] expAddr;
        @(posedge clk);
        #1;
        if (bus.branch_en === 1'b1) begin
            if (expAddrQ.size() == 0) begin
                checkOutput("unexpected_branch_en", 64'(bus.branch_en), 64'd0);
            end else begin
                expAddr = expAddrQ.pop_front();
                checkOutput("branch_addr", 64'(bus.branch_addr), 64'(expAddr));
            end
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic br,
                                 input logic [XLEN-1:0] target,
                                 input logic hreq, input logic res,
                                 input logic clr);
        bus.stall_req = stall;
        bus.br_req    = br;
        bus.br_target = target;
        bus.halt_req  = hreq;
        bus.resume    = res;
        bus.perf_clr  = clr;
`ifdef FETCH_CTRL_TRAP_EN
        bus.trap_req  = 1'b0;
        bus.trap_pc   = '0;
`endif
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        rst        = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Reset held, then released and idled for 5 cycles.
        repeat (2) tick();
        checkOutput("rst_halt",       64'(bus.halt),       64'd0);
        checkOutput("rst_ctrl_state", 64'(bus.ctrl_state), 64'(RUN));
        rst = 1'b1;
        repeat (5) tick();
        checkOutput("idle_halt",         64'(bus.halt),         64'd0);
        checkOutput("idle_branch_en",    64'(bus.branch_en),    64'd0);
        checkOutput("idle_ctrl_state",   64'(bus.ctrl_state),   64'(RUN));
        checkOutput("idle_stall_cycles", 64'(bus.stall_cycles), 64'd0);
        checkOutput("idle_flush_if",     64'(bus.flush_if),     64'd0);
        checkOutput("idle_branch_addr",  64'(bus.branch_addr),  64'd0);

        // Branch redirect with misaligned target, then br_req during FLUSH.
        applyStimulus(1'b0, 1'b1, 32'h0000_0043, 1'b0, 1'b0, 1'b0);
        expAddrQ.push_back(32'h0000_0040);
        tick();
        checkOutput("br_branch_en", 64'(bus.branch_en),  64'd1);
        checkOutput("br_flush_if",  64'(bus.flush_if),   64'd1);
        checkOutput("br_flush_id",  64'(bus.flush_id),   64'd1);
        checkOutput("br_state",     64'(bus.ctrl_state), 64'(FLUSH));
        applyStimulus(1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("flush_br_ignored", 64'(bus.branch_en),  64'd0);
        checkOutput("flush2_flush_if",  64'(bus.flush_if),   64'd1);
        checkOutput("flush2_flush_id",  64'(bus.flush_id),   64'd1);
        checkOutput("flush2_state",     64'(bus.ctrl_state), 64'(FLUSH));
        tick();
        checkOutput("flush_end_flush_if", 64'(bus.flush_if),   64'd0);
        checkOutput("flush_end_state",    64'(bus.ctrl_state), 64'(RUN));
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();

        // Four stall cycles: halt lags by one, counter reaches 4.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("stall_halt_%0d", i), 64'(bus.halt), 64'd1);
        end
        checkOutput("stall_state", 64'(bus.ctrl_state), 64'(STALL));
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("unstall_halt",  64'(bus.halt),         64'd0);
        checkOutput("unstall_state", 64'(bus.ctrl_state),   64'(RUN));
        checkOutput("stall_cycles4", 64'(bus.stall_cycles), 64'd4);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("perf_clr", 64'(bus.stall_cycles), 64'd0);

        // Halt, with stall and branch requests hammering it, then resume.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("halted_state", 64'(bus.ctrl_state), 64'(HALTED));
        applyStimulus(1'b1, 1'b1, 32'h0000_0900, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("halted_halt_%0d", i), 64'(bus.halt), 64'd1);
        end
        checkOutput("halted_no_br",    64'(bus.branch_en),    64'd0);
        checkOutput("halted_no_stall", 64'(bus.stall_cycles), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("resume_halt",  64'(bus.halt),       64'd0);
        checkOutput("resume_state", 64'(bus.ctrl_state), 64'(RUN));
        tick();
        checkOutput("resume_in_run", 64'(bus.ctrl_state), 64'(RUN));

        // Branch and stall together: branch wins, no stall counted.
        applyStimulus(1'b1, 1'b1, 32'h1234_5679, 1'b0, 1'b0, 1'b0);
        expAddrQ.push_back(32'h1234_5678);
        tick();
        checkOutput("brstall_branch_en", 64'(bus.branch_en),  64'd1);
        checkOutput("brstall_state",     64'(bus.ctrl_state), 64'(FLUSH));
        checkOutput("brstall_halt",      64'(bus.halt),       64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("brstall_stall_cycles", 64'(bus.stall_cycles), 64'd0);
        checkOutput("brstall_back_run",     64'(bus.ctrl_state),   64'(RUN));

`ifdef FETCH_CTRL_TRAP_EN
        // Trap beats a simultaneous branch and captures epc.
        applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
        bus.trap_req = 1'b1;
        bus.trap_pc  = 32'h0000_0200;
        expAddrQ.push_back(32'h0000_0100);
        tick();
        checkOutput("trap_branch_en", 64'(bus.branch_en),  64'd1);
        checkOutput("trap_epc",       64'(bus.epc),        64'h200);
        checkOutput("trap_state",     64'(bus.ctrl_state), 64'(FLUSH));
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("trap_back_run", 64'(bus.ctrl_state), 64'(RUN));
`endif

        // Asynchronous reset in the middle of FLUSH.
        applyStimulus(1'b0, 1'b1, 32'h0000_0050, 1'b0, 1'b0, 1'b0);
        expAddrQ.push_back(32'h0000_0050);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_flush_if", 64'(bus.flush_if), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_flush_if",    64'(bus.flush_if),    64'd0);
        checkOutput("async_rst_flush_id",    64'(bus.flush_id),    64'd0);
        checkOutput("async_rst_state",       64'(bus.ctrl_state),  64'(RUN));
        checkOutput("async_rst_branch_en",   64'(bus.branch_en),   64'd0);
        checkOutput("async_rst_branch_addr", 64'(bus.branch_addr), 64'd0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        checkOutput("post_rst_state",       64'(bus.ctrl_state),  64'(RUN));
        checkOutput("post_rst_flush_if",    64'(bus.flush_if),    64'd0);
        checkOutput("post_rst_halt",        64'(bus.halt),        64'd0);
        checkOutput("post_rst_branch_addr", 64'(bus.branch_addr), 64'd0);

        checkOutput("scoreboard_drained", 64'(expAddrQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
